// File: rtl/grid_dumper.sv
// Streams a solved sudoku board out of the grid one tile per beat, row by row,
// converting each one-hot tile to a binary digit; emits a single beat on failure.
module grid_dumper #(
    parameter int GRID_ORD  = 3,
    parameter int GRID_LEN  = GRID_ORD * GRID_ORD,
    parameter int GRID_AREA = GRID_LEN * GRID_LEN,
    parameter int DIGIT_W   = $clog2(GRID_LEN + 1),
    parameter int INDEX_W   = $clog2(GRID_AREA)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          done_success,
    input  logic                          done_failure,
    output logic [$clog2(GRID_LEN)-1:0]   rdrow,
    input  logic [GRID_LEN*GRID_LEN-1:0]  rdvalues,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DIGIT_W-1:0]            out_digit,
    output logic [INDEX_W-1:0]            out_index,
    output logic                          out_last,
    output logic                          out_fail,
    output logic                          busy,
    output logic                          malformed
);

    localparam int ROW_W = $clog2(GRID_LEN);
    localparam logic [ROW_W-1:0]   LAST_RC = ROW_W'(GRID_LEN - 1);
    localparam logic [INDEX_W-1:0] LEN_I   = INDEX_W'(GRID_LEN);

    typedef enum logic [2:0] {IDLE, FETCH, EMIT, FAILBEAT, DONE} state_t;

    state_t             state;
    logic [ROW_W-1:0]   row;
    logic [ROW_W-1:0]   col;
    logic [GRID_LEN-1:0] cells [GRID_LEN];
    logic [DIGIT_W-1:0] tile_digit;
    logic               accept;
    logic               last_cell;

    // Digit 0 doubles as the "not exactly one-hot" marker.
    function automatic logic [DIGIT_W-1:0] decode_tile(input logic [GRID_LEN-1:0] v);
        logic [DIGIT_W-1:0] d;
        int                 n;
        d = '0;
        n = 0;
        for (int i = 0; i < GRID_LEN; i++) begin
            if (v[i]) begin
                n++;
                d = DIGIT_W'(i + 1);
            end
        end
        return (n == 1) ? d : '0;
    endfunction

    always_comb begin
        tile_digit = decode_tile(cells[col]);
        last_cell  = (row == LAST_RC) && (col == LAST_RC);
        out_valid  = (state == EMIT) || (state == FAILBEAT);
        out_fail   = (state == FAILBEAT);
        out_last   = (state == FAILBEAT) || ((state == EMIT) && last_cell);
        out_digit  = (state == EMIT) ? tile_digit : '0;
        out_index  = (state == EMIT) ? (INDEX_W'(row) * LEN_I + INDEX_W'(col)) : '0;
        busy       = (state != IDLE);
        accept     = out_valid && out_ready;
    end

    assign rdrow = row;

    // Row buffer: captured once per row so later rdvalues changes cannot disturb beats.
    always_ff @(posedge clock) begin
        if (state == FETCH) begin
            for (int c = 0; c < GRID_LEN; c++) begin
                cells[c] <= rdvalues[c*GRID_LEN +: GRID_LEN];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            malformed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (done_failure) begin
                        state <= FAILBEAT;
                    end else if (done_success) begin
                        state <= FETCH;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                FETCH: begin
                    state <= EMIT;
                    col   <= '0;
                end
                EMIT: begin
                    if (accept) begin
                        if (tile_digit == '0) begin
                            malformed <= 1'b1;
                        end
                        if (col == LAST_RC) begin
                            col <= '0;
                            if (row == LAST_RC) begin
                                state <= DONE;
                            end else begin
                                row   <= row + 1'b1;
                                state <= FETCH;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                FAILBEAT: begin
                    if (accept) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!done_success && !done_failure) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_dumper.sv
// Scoreboard bench for grid_dumper: stimulus pushes expected beats computed from the
// board contents; a negedge monitor pops and compares every accepted beat.
module tb_grid_dumper;

    localparam int L = 9;

    logic        clock = 1'b0;
    logic        reset;
    logic        done_success;
    logic        done_failure;
    logic [3:0]  rdrow;
    logic [80:0] rdvalues;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_digit;
    logic [6:0]  out_index;
    logic        out_last;
    logic        out_fail;
    logic        busy;
    logic        malformed;

    grid_dumper dut (
        .clock        (clock),
        .reset        (reset),
        .done_success (done_success),
        .done_failure (done_failure),
        .rdrow        (rdrow),
        .rdvalues     (rdvalues),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_digit    (out_digit),
        .out_index    (out_index),
        .out_last     (out_last),
        .out_fail     (out_fail),
        .busy         (busy),
        .malformed    (malformed)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] digit;
        logic [6:0] index;
        logic       last;
        logic       fail;
    } beat_t;

    beat_t      exp_q[$];
    logic [8:0] raw [L][L];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         beats_seen = 0;
    bit         bp_mode = 0;
    bit         have_prev = 0;
    logic [13:0] prev_out;

    // Grid read port model: combinational row lookup.
    always_comb begin
        rdvalues = '0;
        for (int c = 0; c < L; c++) begin
            if (rdrow < 4'd9) rdvalues[c*L +: L] = raw[rdrow][c];
        end
    end

    // Sink readiness: always ready, or random when backpressure is on.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares accepted beats against the scoreboard, and stalled beats for stability.
    always @(negedge clock) begin
        logic [13:0] cur;
        beat_t       e;
        cur = {out_valid, out_digit, out_index, out_last, out_fail};
        if (reset) begin
            have_prev = 0;
        end else begin
            if (have_prev) check("stall_stable", 32'(cur), 32'(prev_out));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {25'd0, out_index}, 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat_%0d", e.index),
                          32'({out_digit, out_index, out_last, out_fail}), 32'(e));
                end
                beats_seen++;
                have_prev = 0;
            end else if (out_valid) begin
                prev_out  = cur;
                have_prev = 1;
            end else begin
                have_prev = 0;
            end
        end
    end

    // Reference: row-major walk of the board; digit is the one-hot position plus one.
    task automatic push_dump();
        beat_t b;
        for (int idx = 0; idx < L*L; idx++) begin
            logic [8:0] v;
            v = raw[idx / L][idx % L];
            b.digit = ($countones(v) == 1) ? 4'($clog2(v) + 1) : 4'd0;
            b.index = 7'(idx);
            b.last  = (idx == L*L - 1);
            b.fail  = 1'b0;
            exp_q.push_back(b);
        end
    endtask

    task automatic push_fail();
        beat_t b;
        b = '{digit: 4'd0, index: 7'd0, last: 1'b1, fail: 1'b1};
        exp_q.push_back(b);
    endtask

    task automatic make_board();
        int perm [L];
        for (int i = 0; i < L; i++) perm[i] = i + 1;
        for (int i = L - 1; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int r = 0; r < L; r++)
            for (int c = 0; c < L; c++)
                raw[r][c] = 9'(1) << (perm[(r*3 + r/3 + c) % L] - 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_success();
        done_success = 1'b1;
        cycles(1);
        done_success = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clock);
        @(negedge clock);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        cycles(1);
    endtask

    initial begin
        int base;
        reset = 1'b1;
        done_success = 1'b0;
        done_failure = 1'b0;
        make_board();
        cycles(3);
        reset = 1'b0;
        @(negedge clock);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_malformed", 32'(malformed), 0);
        check("rst_outs", 32'({out_digit, out_index, out_last, out_fail, rdrow}), 0);
        cycles(1);

        // Solved board, sink always ready, with latency check.
        push_dump();
        done_success = 1'b1;
        cycles(1);
        done_success = 1'b0;
        @(negedge clock);
        check("fetch_cycle", 32'({out_valid, busy}), 32'b01);
        @(negedge clock);
        check("first_beat_lat", 32'({out_valid, out_index}), 32'h80);
        drain("dump1_drain", 200);
        cycles(3);
        check("dump1_busy", 32'(busy), 0);
        check("dump1_malformed", 32'(malformed), 0);

        // Backpressure.
        make_board();
        bp_mode = 1;
        push_dump();
        pulse_success();
        drain("bp_drain", 2000);
        bp_mode = 0;
        cycles(4);

        // Failure: one beat while held, another after re-raise.
        base = beats_seen;
        push_fail();
        done_failure = 1'b1;
        cycles(51);
        check("fail_once", 32'(beats_seen - base), 1);
        done_failure = 1'b0;
        cycles(2);
        push_fail();
        done_failure = 1'b1;
        cycles(4);
        done_failure = 1'b0;
        drain("fail_drain", 20);
        check("fail_twice", 32'(beats_seen - base), 2);

        // Malformed tiles.
        make_board();
        raw[4][7] = 9'b000000000;
        raw[8][0] = 9'b000000011;
        check("pre_malformed", 32'(malformed), 0);
        push_dump();
        pulse_success();
        drain("malf_drain", 200);
        check("post_malformed", 32'(malformed), 1);

        // Reset mid-dump, then restart from index 0.
        make_board();
        base = beats_seen;
        push_dump();
        pulse_success();
        for (int i = 0; i < 200 && beats_seen < base + 31; i++) @(posedge clock);
        #1;
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("midrst_valid", 32'({out_valid, busy, malformed}), 0);
        cycles(2);
        push_dump();
        pulse_success();
        drain("restart_drain", 200);

        // Simultaneous flags: failure wins.
        cycles(3);
        base = beats_seen;
        push_fail();
        done_success = 1'b1;
        done_failure = 1'b1;
        cycles(1);
        done_success = 1'b0;
        done_failure = 1'b0;
        cycles(30);
        drain("both_drain", 10);
        check("both_one_beat", 32'(beats_seen - base), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
